ft232h_mux_framer: RTL



---
 rtl/ft232h_mux_framer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ft232h_mux_framer.sv
// ft232h_mux_framer: round-robin AXIS-to-byte framer in the ftdi_clk domain.
// Each granted word becomes one frame: {4'hA, ch}, then the payload bytes MSB first.
// Optional feature macro: FT232H_FRAMER_CHECKSUM_EN appends an XOR checksum byte.
`timescale 1ns/1ps
module ft232h_mux_framer #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CHANNELS-1:0]            s_tvalid,
  output logic [NUM_CHANNELS-1:0]            s_tready,
  output logic [7:0]                         m_tdata,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               m_tlast
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  // Reject unsupported configurations at elaboration
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_channels
    $error("ft232h_mux_framer: NUM_CHANNELS must be 1..16");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("ft232h_mux_framer: DATA_WIDTH must be a multiple of 8 and >= 8");
  end

`ifdef FT232H_FRAMER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_CHECKSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD} state_t;
`endif

  state_t                  state_q, state_d;
  logic [3:0]              rr_ptr_q, rr_ptr_d;
  logic [3:0]              ch_q, ch_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic                    armed_q;
  logic [3:0]              grant;
  logic                    grant_found;
  int unsigned             cand;
  logic [NUM_CHANNELS-1:0] tv_shift;
  logic [DATA_WIDTH-1:0]   shifted;
`ifdef FT232H_FRAMER_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  // State and datapath registers; armed_q keeps s_tready low for the first cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ch_q     <= ch_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      armed_q  <= 1'b1;
    end
  end

  // Arbitration, next-state logic and output decode
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    ch_d        = ch_q;
    idx_d       = idx_q;
    word_d      = word_q;
    s_tready    = '0;
    m_tvalid    = 1'b0;
    m_tdata     = 8'h00;
    m_tlast     = 1'b0;
    grant       = '0;
    grant_found = 1'b0;
    cand        = 0;
    tv_shift    = '0;
    shifted     = word_q << {idx_q, 3'b000};
`ifdef FT232H_FRAMER_CHECKSUM_EN
    csum = {4'hA, ch_q};
    for (int unsigned b = 0; b < BYTES; b++) begin
      csum = csum ^ word_q[b*8 +: 8];
    end
`endif

    // First valid channel searching upward from rr_ptr with wrap
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NUM_CHANNELS;
      tv_shift = s_tvalid >> cand;
      if (!grant_found && tv_shift[0]) begin
        grant_found = 1'b1;
        grant       = 4'(cand);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (armed_q && grant_found) begin
          s_tready = NUM_CHANNELS'(1) << grant;
          word_d   = DATA_WIDTH'(s_tdata >> (32'(grant) * DATA_WIDTH));
          ch_d     = grant;
          rr_ptr_d = 4'((32'(grant) + 32'd1) % NUM_CHANNELS);
          state_d  = ST_HEADER;
        end
      end
      ST_HEADER: begin
        m_tvalid = 1'b1;
        m_tdata  = {4'hA, ch_q};
        if (m_tready) begin
          idx_d   = '0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        m_tvalid = 1'b1;
        m_tdata  = shifted[DATA_WIDTH-1 -: 8];
`ifdef FT232H_FRAMER_CHECKSUM_EN
        m_tlast  = 1'b0;
`else
        m_tlast  = (idx_q == LAST_IDX);
`endif
        if (m_tready) begin
          if (idx_q == LAST_IDX) begin
`ifdef FT232H_FRAMER_CHECKSUM_EN
            state_d = ST_CHECKSUM;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef FT232H_FRAMER_CHECKSUM_EN
      ST_CHECKSUM: begin
        m_tvalid = 1'b1;
        m_tdata  = csum;
        m_tlast  = 1'b1;
        if (m_tready) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
